alu_resp_checker: RTL

//  Response-side checker for the 8-bit ALU opcode sweep: samples each ALU response
//  (result, cout, z, v) with its stimulus, compares it against an internal golden model,

---
 rtl/alu_resp_checker_if.sv | 24 ++
 rtl/alu_resp_checker.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_resp_checker_if.sv
// Monitor bus carrying one ALU stimulus/response pair per cycle from the ALU output tap
// to the response checker.
interface alu_resp_checker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 5
);
  logic             valid;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             z;
  logic             v;

  modport master (
    output valid, opcode, a, b, cin, result, cout, z, v
  );

  modport slave (
    input valid, opcode, a, b, cin, result, cout, z, v
  );
endinterface

// File: rtl/alu_resp_checker.sv
// Response-side checker for the ALU opcode sweep: compares each response against a golden
// model, counts mismatches, records the first failing opcode and folds responses into a MISR.
module alu_resp_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OPW     = 5,
  parameter int unsigned NUM_OPS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  alu_resp_checker_if.slave   mon_if,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [5:0]          err_count_o,
  output logic [OPW-1:0]      first_err_op_o,
  output logic                first_err_vld_o,
  output logic [15:0]         signature_o
);

  localparam logic [OPW-1:0] LastOp  = OPW'(NUM_OPS - 1);
  localparam logic [15:0]    SigSeed = 16'hFFFF;
  localparam logic [15:0]    SigPoly = 16'h1021;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] exp_op_q, exp_op_d;
  logic [OPW-1:0] first_op_q, first_op_d;
  logic           first_vld_q, first_vld_d;
  logic [5:0]     err_q, err_d;
  logic [15:0]    sig_q, sig_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] gold_res;
  logic             gold_cout, gold_v;
  logic             is_arith, is_basic;
  logic             mismatch;

  // Golden ALU, evaluated for the opcode the sweep expects next.
  always_comb begin
    is_arith = exp_op_q < OPW'(3);
    is_basic = exp_op_q < OPW'(8);
    opb      = (exp_op_q == OPW'(2)) ? ~mon_if.b : mon_if.b;
    sum      = '0;
    case (exp_op_q[2:0])
      3'd0:    sum = {1'b0, mon_if.a} + {1'b0, mon_if.b};
      3'd1:    sum = {1'b0, mon_if.a} + {1'b0, mon_if.b} + {{WIDTH{1'b0}}, mon_if.cin};
      3'd2:    sum = {1'b0, mon_if.a} + {1'b0, opb} + {{WIDTH{1'b0}}, 1'b1};
      3'd3:    sum = {1'b0, mon_if.a & mon_if.b};
      3'd4:    sum = {1'b0, mon_if.a | mon_if.b};
      3'd5:    sum = {1'b0, mon_if.a ^ mon_if.b};
      3'd6:    sum = {1'b0, ~mon_if.a};
      default: sum = {1'b0, mon_if.a};
    endcase
    gold_res  = sum[WIDTH-1:0];
    gold_cout = is_arith & sum[WIDTH];
    gold_v    = is_arith && (mon_if.a[WIDTH-1] == opb[WIDTH-1])
                && (gold_res[WIDTH-1] != mon_if.a[WIDTH-1]);

    mismatch = (mon_if.opcode != exp_op_q);
    if (is_basic) begin
      if (mon_if.result != gold_res || mon_if.cout != gold_cout || mon_if.v != gold_v
          || mon_if.z != (gold_res == '0)) begin
        mismatch = 1'b1;
      end
    end else if (mon_if.z != (mon_if.result == '0)) begin
      mismatch = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    exp_op_d    = exp_op_q;
    first_op_d  = first_op_q;
    first_vld_d = first_vld_q;
    err_d       = err_q;
    sig_d       = sig_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d     = StRun;
          exp_op_d    = '0;
          first_op_d  = '0;
          first_vld_d = 1'b0;
          err_d       = '0;
          sig_d       = SigSeed;
        end
      end
      StRun: begin
        if (mon_if.valid) begin
          exp_op_d = exp_op_q + OPW'(1);
          if (mismatch) begin
            err_d = (err_q == 6'd63) ? err_q : err_q + 6'd1;
            if (!first_vld_q) begin
              first_op_d  = exp_op_q;
              first_vld_d = 1'b1;
            end
          end
          sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? SigPoly : 16'h0000)
                  ^ 16'({mon_if.cout, mon_if.v, mon_if.z, mon_if.result});
          // The last sample wins over a coincident start.
          if (exp_op_q == LastOp) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      exp_op_q    <= '0;
      first_op_q  <= '0;
      first_vld_q <= 1'b0;
      err_q       <= '0;
      sig_q       <= SigSeed;
    end else begin
      state_q     <= state_d;
      exp_op_q    <= exp_op_d;
      first_op_q  <= first_op_d;
      first_vld_q <= first_vld_d;
      err_q       <= err_d;
      sig_q       <= sig_d;
    end
  end

  assign busy_o          = (state_q == StRun);
  assign done_o          = (state_q == StDone);
  assign pass_o          = (state_q == StDone) && (err_q == '0);
  assign err_count_o     = err_q;
  assign first_err_op_o  = first_op_q;
  assign first_err_vld_o = first_vld_q;
  assign signature_o     = sig_q;

endmodule
